// File: rtl/verificador_clusters.sv
// Walks the head entry's cluster bitmap lowest index first, issues one lookup per set bit,
// and ends each entry with a single-cycle zero or suspeito pulse.
module verificador_clusters #(
  parameter int NUM_CLUSTERS    = 8,
  parameter int TAM_ENDERECO    = 64,
  parameter int TAM_HASH_DOIS   = 8,
  parameter int LIMIAR_SUSPEITA = 3,
  parameter int LIMITE_ESPERA   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            saida_valida,
  input  logic [NUM_CLUSTERS-1:0]         bitmap_atual,
  input  logic [TAM_ENDERECO-1:0]         endereco_atual,
  input  logic [TAM_HASH_DOIS-1:0]        hash_atual,
  output logic [NUM_CLUSTERS-1:0]         bitmap_atualizado,
  output logic                            zero,
  output logic                            suspeito,
  output logic                            req_valido,
  input  logic                            req_pronto,
  output logic [$clog2(NUM_CLUSTERS)-1:0] req_cluster,
  output logic [TAM_ENDERECO-1:0]         req_endereco,
  output logic [TAM_HASH_DOIS-1:0]        req_hash,
  input  logic                            resp_valida,
  input  logic                            resp_acerto,
  output logic [15:0]                     total_suspeitos
);

  localparam int CW = $clog2(NUM_CLUSTERS);
  localparam int HW = $clog2(NUM_CLUSTERS + 1);
  localparam int TW = $clog2(LIMITE_ESPERA + 1);
  localparam logic [HW-1:0] LIMIAR    = HW'(LIMIAR_SUSPEITA);
  localparam logic [TW-1:0] TIMER_MAX = TW'(LIMITE_ESPERA - 1);

  typedef enum logic [2:0] {
    OCIOSO, SELECIONA, REQUISITA, AGUARDA_RESP, DESCARTA
  } estado_t;

  estado_t                  state_reg, state_next;
  logic                     motivo_reg, motivo_next;   // 1 = suspeito, 0 = zero
  logic [HW-1:0]            hits_reg, hits_next;
  logic [TW-1:0]            timer_reg, timer_next;
  logic [CW-1:0]            cluster_reg, cluster_next;
  logic [TAM_ENDERECO-1:0]  endereco_reg, endereco_next;
  logic [TAM_HASH_DOIS-1:0] hash_reg, hash_next;
  logic                     zero_reg, suspeito_reg;
  logic [15:0]              total_reg;

  logic [CW-1:0]           menor_idx;
  logic [NUM_CLUSTERS-1:0] mascara;
  logic [NUM_CLUSTERS-1:0] limpo;
  logic [HW-1:0]           hits_inc;
  logic                    conclusao;

  // Priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    menor_idx = '0;
    for (int i = NUM_CLUSTERS - 1; i >= 0; i--) begin
      if (bitmap_atual[i]) menor_idx = CW'(i);
    end
  end

  assign conclusao = (state_reg == AGUARDA_RESP) && (resp_valida || (timer_reg == TIMER_MAX));
  assign mascara   = {{(NUM_CLUSTERS-1){1'b0}}, 1'b1} << cluster_reg;
  assign limpo     = bitmap_atual & ~mascara;
  assign hits_inc  = hits_reg + {{(HW-1){1'b0}}, resp_valida & resp_acerto};

  assign bitmap_atualizado = conclusao ? limpo : bitmap_atual;

  always_comb begin
    state_next    = state_reg;
    motivo_next   = motivo_reg;
    hits_next     = hits_reg;
    timer_next    = timer_reg;
    cluster_next  = cluster_reg;
    endereco_next = endereco_reg;
    hash_next     = hash_reg;
    case (state_reg)
      OCIOSO: begin
        hits_next = '0;
        if (saida_valida) state_next = SELECIONA;
      end
      SELECIONA: begin
        if (!saida_valida) begin
          state_next = OCIOSO;
        end else if (bitmap_atual == '0) begin
          motivo_next = 1'b0;
          state_next  = DESCARTA;
        end else begin
          cluster_next  = menor_idx;
          endereco_next = endereco_atual;
          hash_next     = hash_atual;
          state_next    = REQUISITA;
        end
      end
      REQUISITA: begin
        if (req_pronto) begin
          timer_next = '0;
          state_next = AGUARDA_RESP;
        end
      end
      AGUARDA_RESP: begin
        timer_next = timer_reg + 1'b1;
        if (conclusao) begin
          hits_next = hits_inc;
          // A head that vanished mid-entry is abandoned silently once its lookup ends.
          if (!saida_valida) begin
            state_next = OCIOSO;
          end else if (hits_inc >= LIMIAR) begin
            motivo_next = 1'b1;
            state_next  = DESCARTA;
          end else if (limpo == '0) begin
            motivo_next = 1'b0;
            state_next  = DESCARTA;
          end else begin
            state_next = SELECIONA;
          end
        end
      end
      DESCARTA: state_next = OCIOSO;
      default:  state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= OCIOSO;
      motivo_reg   <= 1'b0;
      hits_reg     <= '0;
      timer_reg    <= '0;
      cluster_reg  <= '0;
      endereco_reg <= '0;
      hash_reg     <= '0;
      zero_reg     <= 1'b0;
      suspeito_reg <= 1'b0;
      total_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      motivo_reg   <= motivo_next;
      hits_reg     <= hits_next;
      timer_reg    <= timer_next;
      cluster_reg  <= cluster_next;
      endereco_reg <= endereco_next;
      hash_reg     <= hash_next;
      zero_reg     <= (state_next == DESCARTA) && !motivo_next;
      suspeito_reg <= (state_next == DESCARTA) && motivo_next;
      if (suspeito_reg && (total_reg != 16'hFFFF)) total_reg <= total_reg + 16'd1;
    end
  end

  assign zero            = zero_reg;
  assign suspeito        = suspeito_reg;
  assign req_valido      = (state_reg == REQUISITA);
  assign req_cluster     = cluster_reg;
  assign req_endereco    = endereco_reg;
  assign req_hash        = hash_reg;
  assign total_suspeitos = total_reg;

endmodule

// File: tb/tb_verificador_clusters.sv
// Directed bench: models the head buffer, predicts requests, write-backs and end pulses
// through scoreboard queues, and compares them as the DUT produces them.
module tb_verificador_clusters;

  localparam int LIMIAR = 3;
  localparam int LIMITE = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        saida_valida;
  logic [7:0]  bitmap_atual;
  logic [63:0] endereco_atual;
  logic [7:0]  hash_atual;
  logic [7:0]  bitmap_atualizado;
  logic        zero, suspeito, req_valido, req_pronto;
  logic [2:0]  req_cluster;
  logic [63:0] req_endereco;
  logic [7:0]  req_hash;
  logic        resp_valida, resp_acerto;
  logic [15:0] total_suspeitos;

  int checks = 0;
  int failures = 0;
  logic [15:0] model_total = 16'd0;

  int         exp_cl[$];
  logic [7:0] exp_wb[$];

  verificador_clusters dut (
    .clk(clk), .reset(reset), .saida_valida(saida_valida), .bitmap_atual(bitmap_atual),
    .endereco_atual(endereco_atual), .hash_atual(hash_atual),
    .bitmap_atualizado(bitmap_atualizado), .zero(zero), .suspeito(suspeito),
    .req_valido(req_valido), .req_pronto(req_pronto), .req_cluster(req_cluster),
    .req_endereco(req_endereco), .req_hash(req_hash), .resp_valida(resp_valida),
    .resp_acerto(resp_acerto), .total_suspeitos(total_suspeitos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plays one head entry through the DUT while acting as buffer and cluster side.
  task automatic run_entry(input string name, input logic [7:0] bmp, input logic [63:0] addr,
                           input logic [7:0] hash, input logic [7:0] hitmask,
                           input bit timeout_mode, input int resp_delay, input int stall);
    logic [7:0] rem, wb, wb_exp;
    int h, c, cl_cur, stall_left, wcnt, n_req;
    bit exp_susp, waiting, done, complete_now;
    exp_cl.delete();
    exp_wb.delete();
    rem = bmp; h = 0; exp_susp = 1'b0;
    while (rem != 8'h00) begin
      c = 0;
      while (!rem[c]) c++;
      exp_cl.push_back(c);
      rem[c] = 1'b0;
      exp_wb.push_back(rem);
      if (!timeout_mode && hitmask[c]) h++;
      if (h >= LIMIAR) begin exp_susp = 1'b1; break; end
    end
    if (exp_susp && model_total != 16'hFFFF) model_total++;
    n_req = exp_cl.size();

    @(negedge clk);
    bitmap_atual = bmp; endereco_atual = addr; hash_atual = hash; saida_valida = 1'b1;
    wb = bmp; stall_left = stall; waiting = 1'b0; wcnt = 0; done = 1'b0; cl_cur = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      bitmap_atual = wb;
      resp_valida = 1'b0; resp_acerto = 1'b0; complete_now = 1'b0;
      if (zero || suspeito) begin
        check({name, "_suspeito"}, 64'(suspeito), 64'(exp_susp));
        check({name, "_zero"}, 64'(zero), 64'(!exp_susp));
        check({name, "_req_left"}, 64'(exp_cl.size()), 64'd0);
        saida_valida = 1'b0; req_pronto = 1'b0;
        done = 1'b1;
        $display("%s: pulse zero=%0b suspeito=%0b after %0d lookups", name, zero, suspeito, n_req);
      end else if (req_valido) begin
        if (exp_cl.size() == 0) begin
          check({name, "_unexpected_req"}, 64'(req_cluster), 64'hFF);
          done = 1'b1;
        end else begin
          check({name, "_req_cluster"}, 64'(req_cluster), 64'(exp_cl[0]));
          check({name, "_req_endereco"}, req_endereco, addr);
          check({name, "_req_hash"}, 64'(req_hash), 64'(hash));
          if (stall_left > 0) begin
            stall_left--; req_pronto = 1'b0;
          end else begin
            req_pronto = 1'b1; cl_cur = exp_cl.pop_front(); waiting = 1'b1; wcnt = 0;
            $display("%s: request cluster=%0d", name, cl_cur);
          end
        end
      end else begin
        req_pronto = 1'b0;
        if (waiting) begin
          wcnt++;
          if (!timeout_mode && wcnt == resp_delay) begin
            resp_valida = 1'b1; resp_acerto = hitmask[cl_cur]; complete_now = 1'b1;
          end else if (timeout_mode && wcnt == LIMITE) begin
            complete_now = 1'b1;
          end else if (timeout_mode && wcnt == LIMITE - 1) begin
            #1 check({name, "_wb_before_timeout"}, 64'(bitmap_atualizado), 64'(bitmap_atual));
          end
        end
      end
      #1;
      if (complete_now) begin
        waiting = 1'b0;
        wb_exp = (exp_wb.size() > 0) ? exp_wb.pop_front() : 8'hxx;
        check({name, "_bitmap_atualizado"}, 64'(bitmap_atualizado), 64'(wb_exp));
      end
      wb = bitmap_atualizado;
    end
    check({name, "_finished"}, 64'(done), 64'd1);
    @(negedge clk);
    check({name, "_pulse_single"}, 64'(zero | suspeito), 64'd0);
    check({name, "_total_suspeitos"}, 64'(total_suspeitos), 64'(model_total));
  endtask

  initial begin
    bit ok;
    reset = 1'b1; saida_valida = 1'b0; bitmap_atual = 8'h00; endereco_atual = '0;
    hash_atual = '0; req_pronto = 1'b0; resp_valida = 1'b0; resp_acerto = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_valido", 64'(req_valido), 64'd0);
    check("reset_zero", 64'(zero | suspeito), 64'd0);
    reset = 1'b0;

    // Idle with no valid head
    bitmap_atual = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_outputs", {req_valido, zero, suspeito}, 64'd0);
      check("idle_req_fields", {req_endereco[31:0], req_hash, 5'd0, req_cluster}, 64'd0);
    end
    check("idle_mirror", 64'(bitmap_atualizado), 64'hA5);
    check("idle_total", 64'(total_suspeitos), 64'd0);
    $display("idle: outputs quiet, bitmap mirrored");

    run_entry("empty", 8'h00, 64'h1111, 8'h11, 8'h00, 1'b0, 1, 0);
    run_entry("two_miss", 8'b0010_0100, 64'hDEAD_BEEF_0000_0001, 8'h5A, 8'h00, 1'b0, 2, 0);
    run_entry("all_hit", 8'hFF, 64'h0123_4567_89AB_CDEF, 8'hC3, 8'hFF, 1'b0, 1, 0);
    run_entry("timeout", 8'b0000_0001, 64'h42, 8'h24, 8'h00, 1'b1, 0, 0);
    run_entry("stall", 8'b0001_0000, 64'hFFFF_0000_AAAA_5555, 8'h99, 8'h10, 1'b0, 3, 5);

    // Asynchronous reset while a lookup is outstanding
    @(negedge clk);
    bitmap_atual = 8'h0F; endereco_atual = 64'h77; hash_atual = 8'h66; saida_valida = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_valido) ok = 1'b1;
    end
    check("rst_req_seen", 64'(ok), 64'd1);
    req_pronto = 1'b1;
    @(negedge clk);
    req_pronto = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_async_outputs", {req_valido, zero, suspeito}, 64'd0);
    check("rst_async_fields", {req_endereco[31:0], req_hash, 5'd0, req_cluster}, 64'd0);
    check("rst_async_total", 64'(total_suspeitos), 64'd0);
    check("rst_async_mirror", 64'(bitmap_atualizado), 64'(bitmap_atual));
    $display("reset: asynchronous clear during AGUARDA_RESP");
    saida_valida = 1'b0;
    model_total = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_entry("fresh", 8'hFF, 64'h9999, 8'h01, 8'h05, 1'b0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
